// File: rtl/chime_sequencer.sv
// ---------------------------------------------------------------------------
// chime_sequencer
//
// N-note doorbell chime engine. A configuration (per-note tone half-period
// thresholds, per-note duration thresholds, repeat count) is accepted through
// a valid/ready handshake. The engine then plays the notes in order as a
// square wave on pwm_out. The whole pass is repeated rep_count extra times.
//
// Optional feature: define CHIME_GAP_EN to insert GAP_CYCLES silent cycles
// between consecutive notes. A GAP of 0 still lasts one cycle. Without the
// macro, notes play back-to-back and no GAP state or gap counter is built.
//
// Ports:
//   int_osc       system clock, rising edge
//   nreset        asynchronous active-low reset
//   start_valid   request to play the presented configuration
//   start_ready   high only in IDLE while abort is low
//   freq_thresh   per-note half-period threshold, note 0 in LSBs, 0 = rest
//   dur_thresh    per-note duration threshold, note 0 in LSBs
//   rep_count     extra passes after the first
//   abort         stop playback immediately (no done pulse)
//   pwm_out       square-wave audio output
//   making_music  high while a chime is in progress
//   done          one-cycle pulse on normal completion
//   note_idx      index of the current note
//   rep_idx       index of the current pass
// ---------------------------------------------------------------------------
module chime_sequencer #(
  parameter int NUM_NOTES  = 4,
  parameter int CNT_W      = 32,
  parameter int REP_W      = 8,
  parameter int GAP_CYCLES = 240000,
  localparam int NI_W      = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1
) (
  input  logic                       int_osc,
  input  logic                       nreset,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [NUM_NOTES*CNT_W-1:0] freq_thresh,
  input  logic [NUM_NOTES*CNT_W-1:0] dur_thresh,
  input  logic [REP_W-1:0]           rep_count,
  input  logic                       abort,
  output logic                       pwm_out,
  output logic                       making_music,
  output logic                       done,
  output logic [NI_W-1:0]            note_idx,
  output logic [REP_W-1:0]           rep_idx
);

  if (NUM_NOTES < 2 || GAP_CYCLES < 0) begin : g_bad_params
    $error("chime_sequencer: NUM_NOTES must be >= 2 and GAP_CYCLES >= 0");
  end

  localparam logic [NI_W-1:0] LAST_NOTE = NI_W'(NUM_NOTES - 1);

`ifdef CHIME_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE, S_GAP} state_t;
  // A zero-length gap still occupies one cycle.
  localparam logic [31:0] GAP_LAST = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
  logic [31:0] gap_cnt, gap_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DONE} state_t;
`endif

  state_t                     state, state_d;
  logic [NUM_NOTES*CNT_W-1:0] freq_q, dur_q;
  logic [REP_W-1:0]           rep_q;
  logic [CNT_W-1:0]           dur_cnt, dur_d, tone_cnt, tone_d;
  logic [NI_W-1:0]            note_d;
  logic [REP_W-1:0]           rep_d;
  logic                       pwm_d;
  logic                       load;
  logic [CNT_W-1:0]           cur_freq, cur_dur;

  assign cur_freq = freq_q[note_idx*CNT_W +: CNT_W];
  assign cur_dur  = dur_q[note_idx*CNT_W +: CNT_W];

  assign start_ready = (state == S_IDLE) && !abort;
  assign done        = (state == S_DONE);
`ifdef CHIME_GAP_EN
  assign making_music = (state == S_PLAY) || (state == S_GAP);
`else
  assign making_music = (state == S_PLAY);
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch; combinational logic uses '='.
  always_comb begin
    state_d = state;
    note_d  = note_idx;
    rep_d   = rep_idx;
    dur_d   = dur_cnt;
    tone_d  = tone_cnt;
    pwm_d   = pwm_out;
    load    = 1'b0;
`ifdef CHIME_GAP_EN
    gap_d   = gap_cnt;
`endif

    case (state)
      S_IDLE: begin
        if (start_valid && start_ready) begin
          load    = 1'b1;
          state_d = S_PLAY;
          note_d  = '0;
          rep_d   = '0;
          dur_d   = '0;
          tone_d  = '0;
          pwm_d   = 1'b0;
        end
      end

      S_PLAY: begin
        dur_d = dur_cnt + 1'b1;
        if (cur_freq == '0) begin
          tone_d = '0;
          pwm_d  = 1'b0;
        end else if (tone_cnt == cur_freq) begin
          tone_d = '0;
          pwm_d  = ~pwm_out;
        end else begin
          tone_d = tone_cnt + 1'b1;
        end

        // End of note: phase reset overrides any toggle in this cycle.
        if (dur_cnt == cur_dur) begin
          dur_d  = '0;
          tone_d = '0;
          pwm_d  = 1'b0;
          if (note_idx != LAST_NOTE) begin
            note_d = note_idx + 1'b1;
          end else if (rep_idx < rep_q) begin
            rep_d  = rep_idx + 1'b1;
            note_d = '0;
          end else begin
            state_d = S_DONE;
          end
`ifdef CHIME_GAP_EN
          if (state_d == S_PLAY) begin
            state_d = S_GAP;
            gap_d   = '0;
          end
`endif
        end
      end

`ifdef CHIME_GAP_EN
      S_GAP: begin
        gap_d = gap_cnt + 1'b1;
        if (gap_cnt == GAP_LAST) state_d = S_PLAY;
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
        note_d  = '0;
        rep_d   = '0;
        pwm_d   = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything once a chime is under way.
    if (abort && state != S_IDLE) begin
      state_d = S_IDLE;
      note_d  = '0;
      rep_d   = '0;
      dur_d   = '0;
      tone_d  = '0;
      pwm_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values computed above.
  always_ff @(posedge int_osc or negedge nreset) begin
    if (!nreset) begin
      state    <= S_IDLE;
      note_idx <= '0;
      rep_idx  <= '0;
      dur_cnt  <= '0;
      tone_cnt <= '0;
      pwm_out  <= 1'b0;
      freq_q   <= '0;
      dur_q    <= '0;
      rep_q    <= '0;
`ifdef CHIME_GAP_EN
      gap_cnt  <= '0;
`endif
    end else begin
      state    <= state_d;
      note_idx <= note_d;
      rep_idx  <= rep_d;
      dur_cnt  <= dur_d;
      tone_cnt <= tone_d;
      pwm_out  <= pwm_d;
`ifdef CHIME_GAP_EN
      gap_cnt  <= gap_d;
`endif
      if (load) begin
        freq_q <= freq_thresh;
        dur_q  <= dur_thresh;
        rep_q  <= rep_count;
      end
    end
  end

endmodule

// File: tb/tb_chime_sequencer.sv
// ---------------------------------------------------------------------------
// tb_chime_sequencer
//
// Directed bench for chime_sequencer (4 notes, 8-bit thresholds, gap of 5
// cycles when CHIME_GAP_EN is defined). On every accepted start, a model
// expands the configuration into the full list of expected per-cycle outputs.
// A compare process checks the DUT against that list on every falling edge.
// Literal expectations (chime lengths, first tone waveform, handshake timing)
// pin the model.
// ---------------------------------------------------------------------------
module tb_chime_sequencer;

  localparam int NN  = 4;
  localparam int CW  = 8;
  localparam int RW  = 8;
  localparam int GAP = 5;

`ifdef CHIME_GAP_EN
  localparam int BASIC_MM  = 63;
  localparam int REPEAT_MM = 199;
  localparam int ABORT_MM  = 83;
  localparam int BOUND_MM  = 6139;
`else
  localparam int BASIC_MM  = 48;
  localparam int REPEAT_MM = 144;
  localparam int ABORT_MM  = 68;
  localparam int BOUND_MM  = 1024;
`endif

  localparam logic [NN*CW-1:0] BASIC_FREQ = 32'h01_00_03_02;  // {1,0,3,2}
  localparam logic [NN*CW-1:0] BASIC_DUR  = 32'h0B_0B_0B_0B;  // all 11

  logic             int_osc = 1'b0;
  logic             nreset  = 1'b0;
  logic             start_valid = 1'b0;
  logic             start_ready;
  logic [NN*CW-1:0] freq_thresh = '0;
  logic [NN*CW-1:0] dur_thresh  = '0;
  logic [RW-1:0]    rep_count   = '0;
  logic             abort = 1'b0;
  logic             pwm_out, making_music, done;
  logic [1:0]       note_idx;
  logic [RW-1:0]    rep_idx;

  chime_sequencer #(
    .NUM_NOTES (NN),
    .CNT_W     (CW),
    .REP_W     (RW),
    .GAP_CYCLES(GAP)
  ) dut (
    .int_osc     (int_osc),
    .nreset      (nreset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .freq_thresh (freq_thresh),
    .dur_thresh  (dur_thresh),
    .rep_count   (rep_count),
    .abort       (abort),
    .pwm_out     (pwm_out),
    .making_music(making_music),
    .done        (done),
    .note_idx    (note_idx),
    .rep_idx     (rep_idx)
  );

  always #5 int_osc = ~int_osc;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       pwm;
    logic       mm;
    logic       dn;
    logic [1:0] note;
    logic [7:0] rep;
  } exp_t;

  exp_t q[$];
  bit   cur_busy = 1'b0;  // DUT was mid-chime during the cycle just ended
  bit   run_cmp  = 1'b0;
  int   mm_cycles   = 0;
  int   done_pulses = 0;

  // Expand one configuration into its cycle-by-cycle output sequence.
  function automatic void build(input logic [NN*CW-1:0] fr, input logic [NN*CW-1:0] dr,
                                input logic [RW-1:0] rc);
    int   f;
    int   d;
    exp_t e;
    for (int r = 0; r <= int'(rc); r++) begin
      for (int n = 0; n < NN; n++) begin
        f = int'(fr[n*CW +: CW]);
        d = int'(dr[n*CW +: CW]);
        for (int c = 0; c <= d; c++) begin
          e.pwm  = (f == 0) ? 1'b0 : 1'(((c / (f + 1)) % 2));
          e.mm   = 1'b1;
          e.dn   = 1'b0;
          e.note = 2'(n);
          e.rep  = 8'(r);
          q.push_back(e);
        end
`ifdef CHIME_GAP_EN
        if (!(r == int'(rc) && n == NN - 1)) begin
          for (int g = 0; g < ((GAP == 0) ? 1 : GAP); g++) begin
            e.pwm  = 1'b0;
            e.mm   = 1'b1;
            e.dn   = 1'b0;
            e.note = 2'((n + 1) % NN);
            e.rep  = 8'((n == NN - 1) ? r + 1 : r);
            q.push_back(e);
          end
        end
`endif
      end
    end
    e    = '0;
    e.dn = 1'b1;
    q.push_back(e);
  endfunction

  always @(posedge int_osc) begin
    if (nreset && run_cmp) begin
      if (cur_busy && abort) q.delete();
      else if (!cur_busy && start_valid && !abort) build(freq_thresh, dur_thresh, rep_count);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge int_osc) begin
    exp_t e;
    if (run_cmp) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        cur_busy = 1'b1;
        check("pwm_out", 32'(pwm_out), 32'(e.pwm));
        check("making_music", 32'(making_music), 32'(e.mm));
        check("done", 32'(done), 32'(e.dn));
        check("start_ready_busy", 32'(start_ready), 32'd0);
        if (e.mm) begin
          check("note_idx", 32'(note_idx), 32'(e.note));
          check("rep_idx", 32'(rep_idx), 32'(e.rep));
        end
      end else begin
        cur_busy = 1'b0;
        check("idle_pwm", 32'(pwm_out), 32'd0);
        check("idle_mm", 32'(making_music), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_ready", 32'(start_ready), 32'(!abort));
      end
      if (making_music) mm_cycles++;
      if (done) done_pulses++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_chime(input logic [NN*CW-1:0] fr, input logic [NN*CW-1:0] dr,
                             input logic [RW-1:0] rc, input bit hold);
    @(posedge int_osc); #1;
    freq_thresh = fr;
    dur_thresh  = dr;
    rep_count   = rc;
    start_valid = 1'b1;
    mm_cycles   = 0;
    done_pulses = 0;
    @(posedge int_osc); #1;  // accepted on this edge
    if (!hold) start_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while ((q.size() != 0 || cur_busy) && n < limit) begin
      @(negedge int_osc);
      n++;
    end
    check("wait_idle_timeout", 32'(n >= limit), 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [5:0] wave;
    int n;

    // Reset state
    repeat (3) @(posedge int_osc);
    @(negedge int_osc);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_mm", 32'(making_music), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_note", 32'(note_idx), 32'd0);
    check("rst_rep", 32'(rep_idx), 32'd0);
    check("rst_ready", 32'(start_ready), 32'd1);
    @(posedge int_osc); #1;
    nreset  = 1'b1;
    run_cmp = 1'b1;

    // Abort in IDLE only blocks the handshake
    @(posedge int_osc); #1;
    abort = 1'b1;
    #1 check("idle_abort_ready", 32'(start_ready), 32'd0);
    @(posedge int_osc); #1;
    abort = 1'b0;

    // Basic chime, with the first six pwm samples of note 0 pinned
    start_chime(BASIC_FREQ, BASIC_DUR, 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge int_osc);
      wave = {wave[4:0], pwm_out};
    end
    check("note0_wave", 32'(wave), 32'b000111);
    wait_idle(500);
    check("basic_mm_cycles", mm_cycles, BASIC_MM);
    check("basic_done_pulses", done_pulses, 1);

    // Repeat: three passes
    start_chime(BASIC_FREQ, BASIC_DUR, 8'd2, 1'b0);
    wait_idle(1000);
    check("repeat_mm_cycles", mm_cycles, REPEAT_MM);
    check("repeat_done_pulses", done_pulses, 1);

    // Abort at cycle 20 with start_valid held through the abort
    start_chime(BASIC_FREQ, BASIC_DUR, 8'd0, 1'b0);
    repeat (19) @(posedge int_osc);
    #1;
    abort = 1'b1;
    start_valid = 1'b1;
    @(negedge int_osc);
    @(negedge int_osc);
    check("abort_mm", 32'(making_music), 32'd0);
    check("abort_pwm", 32'(pwm_out), 32'd0);
    check("abort_ready", 32'(start_ready), 32'd0);
    @(posedge int_osc); #1;
    abort = 1'b0;
    @(negedge int_osc);
    check("post_abort_ready", 32'(start_ready), 32'd1);
    @(posedge int_osc); #1;
    start_valid = 1'b0;
    wait_idle(500);
    check("abort_mm_cycles", mm_cycles, ABORT_MM);
    check("abort_done_pulses", done_pulses, 1);

    // Input isolation with start_valid held continuously
    start_chime(BASIC_FREQ, BASIC_DUR, 8'd0, 1'b1);
    repeat (10) @(posedge int_osc);
    #1;
    freq_thresh = 32'h05_05_05_05;
    dur_thresh  = 32'h02_02_02_02;
    n = 0;
    while (!done && n < 500) begin
      @(negedge int_osc);
      n++;
    end
    check("iso_done_timeout", 32'(n >= 500), 32'd0);
    check("iso_mm_cycles", mm_cycles, BASIC_MM);
    @(negedge int_osc);
    check("iso_ready_after_done", 32'(start_ready), 32'd1);
    @(negedge int_osc);
    check("iso_reaccept", 32'(making_music), 32'd1);
    @(posedge int_osc); #1;
    start_valid = 1'b0;
    wait_idle(500);
    check("iso_done_pulses", done_pulses, 2);

    // Boundary: 1024 one-cycle rests
    start_chime('0, '0, 8'd255, 1'b0);
    wait_idle(8000);
    check("bound_mm_cycles", mm_cycles, BOUND_MM);
    check("bound_done_pulses", done_pulses, 1);

    // Asynchronous reset mid-chime (cycle 16: note 1, pwm high)
    start_chime(BASIC_FREQ, BASIC_DUR, 8'd0, 1'b0);
    repeat (16) @(posedge int_osc);
    #1;
`ifndef CHIME_GAP_EN
    check("pre_rst_pwm", 32'(pwm_out), 32'd1);
    check("pre_rst_note", 32'(note_idx), 32'd1);
`endif
    check("pre_rst_mm", 32'(making_music), 32'd1);
    run_cmp  = 1'b0;
    nreset   = 1'b0;
    q.delete();
    cur_busy = 1'b0;
    #1;
    check("arst_pwm", 32'(pwm_out), 32'd0);
    check("arst_mm", 32'(making_music), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_note", 32'(note_idx), 32'd0);
    check("arst_rep", 32'(rep_idx), 32'd0);
    check("arst_ready", 32'(start_ready), 32'd1);
    @(posedge int_osc); #1;
    nreset = 1'b1;
    @(negedge int_osc);
    run_cmp = 1'b1;

    // Normal operation after reset
    start_chime(BASIC_FREQ, BASIC_DUR, 8'd0, 1'b0);
    wait_idle(500);
    check("post_rst_mm_cycles", mm_cycles, BASIC_MM);
    check("post_rst_done_pulses", done_pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
